can_rx_accept_logic: RTL and testbench
======================================

# can_rx_accept_logic

Receive-side counterpart of the TX priority path: takes each completed 128-bit frame from the CAN bit engine, applies up to four acceptance filters, and writes accepted frames into the RX FIFO. It runs entirely in the system clock domain; the bit engine's frame-valid strobe is already synchronized before it reaches this block. Status strobes feed the interrupt/status register block.

## Interface
- NUM_FILTERS, 4: number of acceptance filter pairs (1–4).
- FRAME_W, 128: frame width. Bits [127:96] are the ID word, [95:64] the DLC word, [63:0] the data.
- i_sys_clk  in  1  system clock; the only clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_cen  in  1  core enable.
- i_rx_valid  in  1  one-cycle strobe: a complete frame is present on i_rx_data.
- i_rx_data  in  FRAME_W  received frame.
- i_afr  in  NUM_FILTERS  filter enable bits; bit k enables filter k.
- i_afmr  in  32*NUM_FILTERS  mask for filter k in [32k+31:32k].
- i_afir  in  32*NUM_FILTERS  ID for filter k in [32k+31:32k].
- i_rx_full  in  1  RX FIFO full.
- o_fifo_w_en  out  1  RX FIFO write strobe.
- o_fifo_w_data  out  FRAME_W  frame to write; registered.
- o_rxok  out  1  pulse: frame written.
- o_rxofl  out  1  pulse: accepted frame dropped because the FIFO was full.
- o_rx_rej  out  1  pulse: frame rejected by the filters.
- o_rx_drop  out  1  pulse: i_rx_valid arrived while the block was not in IDLE.
- o_rx_count  out  8  count of frames written; wraps 255 to 0.

## Operation
- States are IDLE, FILTER and WRITE.
- **IDLE:** if i_cen=1 and i_rx_valid=1, latch i_rx_data into the frame register and go to FILTER. Otherwise stay in IDLE.
- **FILTER:**
  - A frame matches filter k when i_afr[k]=1 and (ID & afmr_k) == (afir_k & afmr_k).
  - If i_afr is all zero, every frame is accepted.
  - Accept: go to WRITE.
  - Reject: assert o_rx_rej for this cycle and go to IDLE.
- **WRITE:**
  - If i_rx_full=0: o_fifo_w_en=1, o_rxok=1, and o_rx_count increments.
  - If i_rx_full=1: o_rxofl=1 and no write.
  - Always go to IDLE.
- **Frame during a busy state:** i_rx_valid=1 in FILTER or WRITE causes o_rx_drop=1 on the next cycle. The new frame is discarded and the frame in flight is unaffected.
- **Core disable:** i_cen=0 in any state forces the next state to IDLE. An in-flight frame is abandoned and no strobes are raised for it.
- **Reset:** i_reset forces the state to IDLE. All outputs go to 0: o_fifo_w_data=0, o_rx_count=0, all strobes 0. This applies mid-frame as well.
- **Output decoding:** o_fifo_w_en, o_rxok, o_rxofl and o_rx_rej are decoded combinationally from the state and i_rx_full. o_rx_drop is registered.
- **Filter configuration:** i_afr, i_afmr and i_afir are sampled only in FILTER. Changing them at any other time has no effect on a frame in flight.

## Timing
- i_rx_valid high in cycle N (IDLE state) → FILTER in cycle N+1 → o_fifo_w_en in cycle N+2 when accepted and the FIFO is not full.
- o_fifo_w_data is stable from cycle N+1 until the next capture.
- A rejected frame produces o_rx_rej in cycle N+1.
- The block is back in IDLE at N+2 after a reject and at N+3 after a write. The earliest next capture is in that cycle.
- Each strobe is exactly one cycle wide.
- o_rx_count updates on the edge that ends the write cycle.

## Configuration
- **CAN_RX_FILTER_EN defined:** filtering as described above.
- **CAN_RX_FILTER_EN undefined:**
  - The filter compare logic is not built; i_afr, i_afmr and i_afir are ignored.
  - Every frame is accepted and o_rx_rej stays 0.
  - The FILTER state is still traversed, so latency is identical in both builds.

## Structure
- Shared package can_pkg holds:
  - the rx state enum;
  - frame field positions (ID_HI=127, ID_LO=96, DLC_HI=95, DLC_LO=64);
  - the MAX_FILTERS=4 constant.
- Sub-module can_acc_filter is purely combinational. It takes the ID, i_afr, i_afmr and i_afir and returns a one-bit accept. It is instantiated only under CAN_RX_FILTER_EN.

## Test plan
- Reset, then i_afr=0 and a frame with ID 0x12345678 → o_fifo_w_en at N+2 with o_fifo_w_data equal to the frame, o_rxok=1, o_rx_count=1.
- i_afr=4'b0001, afmr0=0xFFE00000, afir0=0x24600000; frame ID 0x246xxxxx → written; frame ID 0x24800000 → o_rx_rej at N+1, no write.
- i_rx_full=1 with an accepted frame → o_rxofl=1 at N+2, o_fifo_w_en=0, o_rx_count unchanged.
- Second i_rx_valid at N+1 → o_rx_drop=1 at N+2; the first frame is still written.
- i_cen dropped in FILTER → IDLE next cycle, no strobes. Reset asserted in WRITE → all outputs 0 immediately.
- 256 accepted frames → o_rx_count wraps to 0.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN receive definitions: rx state encoding,
// frame field positions and the filter bank limit.
package can_pkg;

  localparam int MAX_FILTERS = 4;

  localparam int ID_HI  = 127;
  localparam int ID_LO  = 96;
  localparam int DLC_HI = 95;
  localparam int DLC_LO = 64;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_FILTER,
    RX_WRITE
  } rx_state_t;

endpackage

// File: rtl/can_acc_filter.sv
// Combinational acceptance filter bank: accepts when any enabled
// mask/ID pair matches, or when no filter is enabled at all.
module can_acc_filter #(
  parameter int NUM_FILTERS = 4
) (
  input  logic [31:0]             i_id,
  input  logic [NUM_FILTERS-1:0]  i_afr,
  input  logic [32*NUM_FILTERS-1:0] i_afmr,
  input  logic [32*NUM_FILTERS-1:0] i_afir,
  output logic                    o_accept
);

  logic [31:0] w_mask;
  logic [31:0] w_ref;

  always_comb begin
    o_accept = ~|i_afr;
    w_mask   = '0;
    w_ref    = '0;
    for (int k = 0; k < NUM_FILTERS; k++) begin
      w_mask = i_afmr[32*k +: 32];
      w_ref  = i_afir[32*k +: 32];
      if (i_afr[k] && ((i_id & w_mask) == (w_ref & w_mask)))
        o_accept = 1'b1;
    end
  end

endmodule

// File: rtl/can_rx_accept_logic.sv
// RX accept path: capture frame, filter, write to RX FIFO.
// Optional acceptance filtering is built when CAN_RX_FILTER_EN is defined.
module can_rx_accept_logic
  import can_pkg::*;
#(
  parameter int NUM_FILTERS = 4,
  parameter int FRAME_W     = 128
) (
  input  logic                      i_sys_clk,
  input  logic                      i_reset,
  input  logic                      i_cen,
  input  logic                      i_rx_valid,
  input  logic [FRAME_W-1:0]        i_rx_data,
  input  logic [NUM_FILTERS-1:0]    i_afr,
  input  logic [32*NUM_FILTERS-1:0] i_afmr,
  input  logic [32*NUM_FILTERS-1:0] i_afir,
  input  logic                      i_rx_full,
  output logic                      o_fifo_w_en,
  output logic [FRAME_W-1:0]        o_fifo_w_data,
  output logic                      o_rxok,
  output logic                      o_rxofl,
  output logic                      o_rx_rej,
  output logic                      o_rx_drop,
  output logic [7:0]                o_rx_count
);

  rx_state_t          r_state;
  rx_state_t          w_next;
  logic [FRAME_W-1:0] r_frame;
  logic [7:0]         r_count;
  logic               r_drop;
  logic               w_accept;
  logic               w_capture;

`ifdef CAN_RX_FILTER_EN
  can_acc_filter #(
    .NUM_FILTERS(NUM_FILTERS)
  ) u_filter (
    .i_id    (r_frame[ID_HI:ID_LO]),
    .i_afr   (i_afr),
    .i_afmr  (i_afmr),
    .i_afir  (i_afir),
    .o_accept(w_accept)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{i_afr, i_afmr, i_afir};
  assign w_accept     = 1'b1;
`endif

  assign w_capture = (r_state == RX_IDLE) && i_cen && i_rx_valid;

  // Strobes are gated by i_cen so an abandoned frame raises nothing
  always_comb begin
    w_next      = r_state;
    o_fifo_w_en = 1'b0;
    o_rxok      = 1'b0;
    o_rxofl     = 1'b0;
    o_rx_rej    = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (w_capture)
          w_next = RX_FILTER;
      end
      RX_FILTER: begin
        if (!i_cen) begin
          w_next = RX_IDLE;
        end else if (w_accept) begin
          w_next = RX_WRITE;
        end else begin
          w_next   = RX_IDLE;
          o_rx_rej = 1'b1;
        end
      end
      RX_WRITE: begin
        w_next = RX_IDLE;
        if (i_cen) begin
          if (!i_rx_full) begin
            o_fifo_w_en = 1'b1;
            o_rxok      = 1'b1;
          end else begin
            o_rxofl = 1'b1;
          end
        end
      end
      default: w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= RX_IDLE;
      r_frame <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drop  <= i_rx_valid && (r_state != RX_IDLE);
      if (w_capture)
        r_frame <= i_rx_data;
      if (o_fifo_w_en)
        r_count <= r_count + 8'd1;
    end
  end

  assign o_fifo_w_data = r_frame;
  assign o_rx_count    = r_count;
  assign o_rx_drop     = r_drop;

endmodule

// File: tb/tb_can_rx_accept_logic.sv
// Scoreboard bench for can_rx_accept_logic (both filter builds).
module tb_can_rx_accept_logic;

  localparam int NF = 4;
  localparam int FW = 128;

`ifdef CAN_RX_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            cen;
  logic            valid;
  logic [FW-1:0]   data;
  logic [NF-1:0]   afr;
  logic [32*NF-1:0] afmr;
  logic [32*NF-1:0] afir;
  logic            full;
  logic            w_en;
  logic [FW-1:0]   w_data;
  logic            rxok;
  logic            rxofl;
  logic            rej;
  logic            drop;
  logic [7:0]      cnt;

  can_rx_accept_logic #(
    .NUM_FILTERS(NF),
    .FRAME_W    (FW)
  ) dut (
    .i_sys_clk    (clk),
    .i_reset      (rst),
    .i_cen        (cen),
    .i_rx_valid   (valid),
    .i_rx_data    (data),
    .i_afr        (afr),
    .i_afmr       (afmr),
    .i_afir       (afir),
    .i_rx_full    (full),
    .o_fifo_w_en  (w_en),
    .o_fifo_w_data(w_data),
    .o_rxok       (rxok),
    .o_rxofl      (rxofl),
    .o_rx_rej     (rej),
    .o_rx_drop    (drop),
    .o_rx_count   (cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            kind;
    logic [FW-1:0] frm;
    logic [7:0]    cnt;
    int            at;
  } exp_t;

  exp_t       q[$];
  int         dq[$];
  logic [7:0] mcnt = 8'd0;

  task automatic check(input string name,
                       input logic [FW-1:0] act,
                       input logic [FW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [31:0] id,
                                       input logic [7:0] n);
    return {id, 24'h0, n, 32'hCAFE_0000, ~id};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame; acc_f is the hand-computed filtered verdict
  task automatic send(input logic [31:0] id, input logic [7:0] n,
                      input bit acc_f);
    exp_t e;
    bit   acc;
    acc    = FILT ? acc_f : 1'b1;
    data   = mk(id, n);
    valid  = 1'b1;
    e.frm  = data;
    e.cnt  = mcnt;
    e.at   = acc ? cyc + 2 : cyc + 1;
    e.kind = acc ? (full ? 1 : 0) : 2;
    q.push_back(e);
    if (acc && !full)
      mcnt++;
    tick();
    valid = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int   k;
    if (drop) begin
      if (dq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL drop_unexp: got drop at cyc %0d want none", cyc);
      end else begin
        check("drop_cyc", FW'(cyc), FW'(dq.pop_front()));
      end
    end
    if (w_en || rxofl || rej) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL strobe_unexp: got %b%b%b at cyc %0d want none",
                 w_en, rxofl, rej, cyc);
      end else begin
        e = q.pop_front();
        k = w_en ? 0 : (rxofl ? 1 : 2);
        check("onehot", FW'({w_en, rxofl, rej}),
              FW'(e.kind == 0 ? 3'b100 : (e.kind == 1 ? 3'b010 : 3'b001)));
        check("kind", FW'(k), FW'(e.kind));
        check("at_cyc", FW'(cyc), FW'(e.at));
        check("rxok", FW'(rxok), FW'(e.kind == 0));
        if (e.kind != 2) begin
          check("w_data", w_data, e.frm);
          check("cnt_pre", FW'(cnt), FW'(e.cnt));
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    cen   = 1'b1;
    valid = 1'b0;
    data  = '0;
    afr   = '0;
    afmr  = '0;
    afir  = '0;
    full  = 1'b0;
    #1;
    check("rst_w_en", FW'(w_en), '0);
    check("rst_data", w_data, '0);
    check("rst_cnt", FW'(cnt), '0);
    check("rst_strb", FW'({rxok, rxofl, rej, drop}), '0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    send(32'h1234_5678, 8'd1, 1'b1);
    tick();
    tick();
    check("cnt_after1", FW'(cnt), FW'(8'd1));

    afr              = 4'b0001;
    afmr[31:0]       = 32'hFFE0_0000;
    afir[31:0]       = 32'h2460_0000;
    afmr[95:64]      = 32'hFFFF_FFFF;
    afir[95:64]      = 32'hABCD_0001;
    send(32'h2461_2345, 8'd2, 1'b1);
    tick(); tick();
    send(32'h2480_0000, 8'd3, 1'b0);
    tick(); tick();
    send(32'h247F_FFFF, 8'd4, 1'b1);
    tick(); tick();
    send(32'h2440_0000, 8'd5, 1'b0);
    tick(); tick();

    afr = 4'b0100;
    send(32'hABCD_0001, 8'd6, 1'b1);
    tick(); tick();
    send(32'hABCD_0000, 8'd7, 1'b0);
    tick(); tick();
    send(32'h2461_2345, 8'd8, 1'b0);
    tick(); tick();
    afr = 4'b0101;
    send(32'h2461_2345, 8'd9, 1'b1);
    tick(); tick();
    check("cnt_filt", FW'(cnt), FW'(mcnt));

    full = 1'b1;
    send(32'h2461_0000, 8'd10, 1'b1);
    tick(); tick();
    full = 1'b0;
    check("cnt_ofl", FW'(cnt), FW'(mcnt));

    send(32'h2462_0000, 8'd11, 1'b1);
    data  = mk(32'h2463_0000, 8'd12);
    valid = 1'b1;
    dq.push_back(cyc + 1);
    tick();
    valid = 1'b0;
    tick();
    tick();

    data  = mk(32'h2464_0000, 8'd13);
    valid = 1'b1;
    tick();
    cen   = 1'b0;
    valid = 1'b0;
    tick();
    cen = 1'b1;
    tick();
    cen   = 1'b0;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    cen   = 1'b1;
    tick();
    check("cnt_cen", FW'(cnt), FW'(mcnt));

    data  = mk(32'h2465_0000, 8'd14);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    check("pre_rst_w_en", FW'(w_en), FW'(1'b1));
    rst = 1'b1;
    #1;
    check("midrst_w_en", FW'({w_en, rxok}), '0);
    check("midrst_data", w_data, '0);
    check("midrst_cnt", FW'(cnt), '0);
    tick();
    rst  = 1'b0;
    mcnt = 8'd0;
    tick();

    afr = '0;
    for (int i = 0; i < 256; i++) begin
      send(32'h0100_0000 + i, 8'(i), 1'b1);
      tick();
      tick();
    end
    check("cnt_wrap", FW'(cnt), FW'(8'd0));

    tick(); tick(); tick();
    check("q_empty", FW'(q.size()), '0);
    check("dq_empty", FW'(dq.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
